// File: rtl/stream_sched_pkg.sv
// -----------------------------------------------------------------------------
// stream_sched_pkg
//   Shared definitions for the stream scheduler: FSM state encoding, default
//   parameter values, counter width and a select-width helper.
// -----------------------------------------------------------------------------
package stream_sched_pkg;

    localparam int NCH_DEF   = 4;
    localparam int DW_DEF    = 16;
    localparam int BURST_DEF = 4;
    localparam int CNT_W     = 16;
    localparam int BCNT_W    = 4;   // holds BURST up to 15

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARB   = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_ARB   = ST_ARB,
        S_RUN   = ST_RUN,
        S_DRAIN = ST_DRAIN
    } state_t;

    // Width of a channel index; never narrower than one bit.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_sched_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational rotating-priority picker. Searches req[] starting at
//   last+1 with wrap-around and returns the first set index.
// Ports:
//   req   in  NCH  request vector
//   last  in  SW   most recently granted index
//   valid out 1    some request is set
//   idx   out SW   chosen index (0 when valid=0)
// -----------------------------------------------------------------------------
module rr_pick
    import stream_sched_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int SW  = sel_w(NCH_DEF)
) (
    input  logic [NCH-1:0] req,
    input  logic [SW-1:0]  last,
    output logic           valid,
    output logic [SW-1:0]  idx
);

    logic [SW-1:0] w_c;

    function automatic int rr_wrap(input int base, input int off);
        int s;
        s = base + off;
        return (s >= NCH) ? s - NCH : s;
    endfunction

    // Scan from the farthest candidate to the nearest so the channel closest
    // after 'last' is the one that sticks.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        valid = 1'b0;
        idx   = '0;
        w_c   = '0;
        for (int k = NCH; k >= 1; k--) begin
            w_c = SW'(rr_wrap(int'(last), k));
            if (req[w_c]) begin
                valid = 1'b1;
                idx   = w_c;
            end
        end
    end

endmodule

// File: rtl/stream_sched.sv
// -----------------------------------------------------------------------------
// stream_sched
//   Round-robin scheduler time-sharing one FIFO-to-FIFO word engine among NCH
//   source/destination FIFO pairs. Grants a channel for up to BURST words and
//   only switches once the engine has finished its current word.
// Optional build macro: STREAM_SCHED_STATS_EN enables per-channel saturating
//   completed-word counters on ch_cnt; otherwise ch_cnt is tied to zero.
// Ports:
//   CLK, RSTN (async, active-low), EN        clock / reset / enable
//   src_empty, src_rd, src_data              channel source FIFOs
//   dst_full, dst_wr, dst_data               channel destination FIFOs
//   eng_cs, eng_empty, eng_full, eng_di      to the engine
//   eng_rd, eng_wr, eng_do                   from the engine
//   busy, cur_ch, ch_cnt                     status
// -----------------------------------------------------------------------------
module stream_sched
    import stream_sched_pkg::*;
#(
    parameter int NCH   = NCH_DEF,
    parameter int DW    = DW_DEF,
    parameter int BURST = BURST_DEF
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic                 EN,
    input  logic [NCH-1:0]       src_empty,
    output logic [NCH-1:0]       src_rd,
    input  logic [NCH*DW-1:0]    src_data,
    input  logic [NCH-1:0]       dst_full,
    output logic [NCH-1:0]       dst_wr,
    output logic [DW-1:0]        dst_data,
    output logic                 eng_cs,
    output logic                 eng_empty,
    output logic                 eng_full,
    input  logic                 eng_rd,
    output logic [DW-1:0]        eng_di,
    input  logic                 eng_wr,
    input  logic [DW-1:0]        eng_do,
    output logic                 busy,
    output logic [2:0]           cur_ch,
    output logic [NCH*CNT_W-1:0] ch_cnt
);

    localparam int SW = sel_w(NCH);
    localparam logic [NCH-1:0] ONE_HOT0 = NCH'(1);

    state_t            r_state;
    logic [SW-1:0]     r_sel;
    logic [SW-1:0]     r_last;
    logic [BCNT_W-1:0] r_burst_cnt;
    logic              r_in_flight;

    logic              w_word_busy;
    logic              w_burst_done;
    logic [NCH-1:0]    w_eligible;
    logic              w_pick_valid;
    logic [SW-1:0]     w_pick_idx;

    // A word is in progress from its RD strobe until its WR strobe.
    assign w_word_busy  = r_in_flight | eng_rd;
    assign w_burst_done = (r_burst_cnt == BCNT_W'(BURST));
    assign w_eligible   = ~src_empty & ~dst_full;

    rr_pick #(.NCH(NCH), .SW(SW)) u_pick (
        .req   (w_eligible),
        .last  (r_last),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

    // Mux follows the registered select only, so it cannot move mid-word.
    assign eng_empty = src_empty[r_sel];
    assign eng_full  = dst_full[r_sel];
    assign eng_di    = src_data[r_sel*DW +: DW];
    assign dst_data  = eng_do;
    assign src_rd    = eng_rd ? (ONE_HOT0 << r_sel) : '0;
    assign dst_wr    = eng_wr ? (ONE_HOT0 << r_sel) : '0;

    assign eng_cs = (r_state == S_RUN) & EN & ~w_burst_done;
    assign busy   = (r_state != S_IDLE);
    assign cur_ch = 3'(r_sel);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state     <= S_IDLE;
            r_sel       <= '0;
            r_last      <= SW'(NCH - 1);
            r_burst_cnt <= '0;
            r_in_flight <= 1'b0;
        end else begin
            if (eng_rd)
                r_in_flight <= 1'b1;
            else if (eng_wr)
                r_in_flight <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (EN)
                        r_state <= S_ARB;
                end
                S_ARB: begin
                    if (!EN) begin
                        r_state <= S_IDLE;
                    end else if (w_pick_valid) begin
                        r_sel       <= w_pick_idx;
                        r_last      <= w_pick_idx;
                        r_burst_cnt <= '0;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (eng_wr && !w_burst_done)
                        r_burst_cnt <= r_burst_cnt + 1'b1;
                    // A full destination alone keeps us here; the engine stalls itself.
                    if (!w_word_busy && (eng_empty || !EN || w_burst_done))
                        r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    // Covers the engine's FIN cycle with eng_cs low.
                    r_state <= EN ? S_ARB : S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef STREAM_SCHED_STATS_EN
    logic [CNT_W-1:0] r_ch_cnt [NCH];

    // NOTE: the counter array is a small flop bank, so it takes the async reset like any state.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < NCH; i++)
                r_ch_cnt[i] <= '0;
        end else if (r_state == S_RUN && eng_wr && r_ch_cnt[r_sel] != '1) begin
            r_ch_cnt[r_sel] <= r_ch_cnt[r_sel] + 1'b1;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_cnt
        assign ch_cnt[g*CNT_W +: CNT_W] = r_ch_cnt[g];
    end
`else
    assign ch_cnt = '0;
`endif

endmodule

// File: tb/tb_stream_sched.sv
// -----------------------------------------------------------------------------
// tb_stream_sched
//   Self-checking bench for stream_sched. Provides behavioural source and
//   destination FIFOs plus an inverter engine, drives directed and random
//   traffic, and compares the delivered word order, data and counters against
//   a round-robin reference computed from the remaining FIFO occupancy.
// -----------------------------------------------------------------------------
module tb_stream_sched;
    import stream_sched_pkg::*;

    localparam int NCH   = 4;
    localparam int DW    = 16;
    localparam int BURST = 4;
    localparam int DEPTH = 256;
    localparam int LOGN  = 1024;

    logic                 CLK = 1'b0;
    logic                 RSTN;
    logic                 EN;
    logic [NCH-1:0]       src_empty, src_rd, dst_full, dst_wr;
    logic [NCH*DW-1:0]    src_data;
    logic [DW-1:0]        dst_data, eng_di, eng_do;
    logic                 eng_cs, eng_empty, eng_full, eng_rd, eng_wr, busy;
    logic [2:0]           cur_ch;
    logic [NCH*CNT_W-1:0] ch_cnt;

    always #5 CLK = ~CLK;

    stream_sched #(.NCH(NCH), .DW(DW), .BURST(BURST)) dut (
        .CLK(CLK), .RSTN(RSTN), .EN(EN),
        .src_empty(src_empty), .src_rd(src_rd), .src_data(src_data),
        .dst_full(dst_full), .dst_wr(dst_wr), .dst_data(dst_data),
        .eng_cs(eng_cs), .eng_empty(eng_empty), .eng_full(eng_full),
        .eng_rd(eng_rd), .eng_di(eng_di), .eng_wr(eng_wr), .eng_do(eng_do),
        .busy(busy), .cur_ch(cur_ch), .ch_cnt(ch_cnt)
    );

    // ---------------- source FIFOs (first-word-fall-through) ----------------
    logic [DW-1:0] src_mem [NCH][DEPTH];
    int src_wp [NCH] = '{default: 0};
    int src_rp [NCH] = '{default: 0};
    for (genvar g = 0; g < NCH; g++) begin : g_src
        assign src_empty[g]          = (src_rp[g] == src_wp[g]);
        assign src_data[g*DW +: DW]  = src_mem[g][src_rp[g] % DEPTH];
    end

    // ---------------- destination capture + global write order --------------
    logic [DW-1:0] dst_mem [NCH][DEPTH];
    int dst_wp [NCH] = '{default: 0};
    int ord_log [LOGN];
    int ord_n = 0;

    always @(posedge CLK) begin
        for (int i = 0; i < NCH; i++) begin
            if (src_rd[i]) src_rp[i] <= src_rp[i] + 1;
            if (dst_wr[i]) begin
                dst_mem[i][dst_wp[i] % DEPTH] <= dst_data;
                dst_wp[i]                     <= dst_wp[i] + 1;
                ord_log[ord_n % LOGN]         <= i;
            end
        end
        if (dst_wr != '0) ord_n <= ord_n + 1;
    end

    // ---------------- inverter engine ----------------
    typedef enum logic [2:0] {E_IDLE, E_RD, E_W1, E_W2, E_WR, E_FIN} eng_t;
    eng_t          e_st;
    logic [DW-1:0] e_data;

    assign eng_rd = (e_st == E_RD);
    assign eng_wr = (e_st == E_WR) && !eng_full;
    assign eng_do = e_data;

    always @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            e_st   <= E_IDLE;
            e_data <= '0;
        end else begin
            case (e_st)
                E_IDLE: if (eng_cs && !eng_empty) e_st <= E_RD;
                E_RD:   begin e_data <= ~eng_di; e_st <= E_W1; end
                E_W1:   e_st <= E_W2;
                E_W2:   e_st <= E_WR;
                E_WR:   if (!eng_full) e_st <= E_FIN;
                default: e_st <= E_IDLE;
            endcase
        end
    end

    // ---------------- protocol monitor (samples on falling edge) ------------
    int bad_strobe = 0, bad_full = 0, bad_gap = 0, n_switch = 0, cs_count = 0;
    int rd_cnt [NCH] = '{default: 0};
    logic       cs_h1 = 1'b0, cs_h2 = 1'b0;
    logic [2:0] prev_ch = 3'd0;

    always @(negedge CLK) begin
        if (!RSTN) begin
            prev_ch = 3'd0;
            cs_h1   = 1'b0;
            cs_h2   = 1'b0;
        end else begin
            if (src_rd != '0 && src_rd != (NCH'(1) << cur_ch)) bad_strobe++;
            if (dst_wr != '0 && dst_wr != (NCH'(1) << cur_ch)) bad_strobe++;
            if ((dst_wr & dst_full) != '0) bad_full++;
            if (cur_ch != prev_ch) begin
                n_switch++;
                if (cs_h1 || cs_h2) bad_gap++;
            end
            for (int i = 0; i < NCH; i++) if (src_rd[i]) rd_cnt[i]++;
            if (eng_cs) cs_count++;
            cs_h2   = cs_h1;
            cs_h1   = eng_cs;
            prev_ch = cur_ch;
        end
    end

    // ---------------- checking helpers ----------------
    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    logic [DW-1:0] exp_q [NCH][$];
    int exp_ord [$];
    int exp_cnt [NCH] = '{default: 0};
    int dst_rd  [NCH] = '{default: 0};
    int ord_chk    = 0;
    int model_last = NCH - 1;

    task automatic load(input int ch, input logic [DW-1:0] w);
        src_mem[ch][src_wp[ch] % DEPTH] = w;
        src_wp[ch]++;
        exp_q[ch].push_back(~w);
    endtask

    // Round-robin reference: from the channel after the last grant, serve the
    // next non-empty channel for min(BURST, remaining) words, repeat.
    task automatic plan();
        int rem [NCH];
        int last, c, n;
        bit any;
        for (int i = 0; i < NCH; i++) rem[i] = src_wp[i] - src_rp[i];
        last = model_last;
        forever begin
            any = 1'b0;
            for (int i = 0; i < NCH; i++) if (rem[i] > 0) any = 1'b1;
            if (!any) break;
            c = last;
            for (int k = 0; k < NCH; k++) begin
                c = (c + 1) % NCH;
                if (rem[c] > 0) break;
            end
            n = (rem[c] < BURST) ? rem[c] : BURST;
            repeat (n) exp_ord.push_back(c);
            rem[c] -= n;
            last = c;
        end
        model_last = last;
    endtask

    task automatic check_data(input string tag);
        for (int i = 0; i < NCH; i++) begin
            while (dst_rd[i] < dst_wp[i]) begin
                if (exp_q[i].size() == 0) begin
                    check($sformatf("%s_extra_ch%0d", tag, i), dst_wp[i] - dst_rd[i], 0);
                    dst_rd[i] = dst_wp[i];
                end else begin
                    check($sformatf("%s_data_ch%0d", tag, i),
                          dst_mem[i][dst_rd[i] % DEPTH], exp_q[i].pop_front());
                    dst_rd[i]++;
                end
            end
        end
    endtask

    task automatic check_cnt(input string tag);
        for (int i = 0; i < NCH; i++) begin
`ifdef STREAM_SCHED_STATS_EN
            check($sformatf("%s_ch_cnt%0d", tag, i), ch_cnt[i*CNT_W +: CNT_W], exp_cnt[i]);
`else
            check($sformatf("%s_ch_cnt%0d", tag, i), ch_cnt[i*CNT_W +: CNT_W], 0);
`endif
        end
    endtask

    task automatic finish_run(input string tag);
        int total, budget, e;
        total  = exp_ord.size();
        budget = total * 12 + 40;
        while (ord_n < ord_chk + total && budget > 0) begin
            tick();
            budget--;
        end
        tick(4);
        check({tag, "_words"}, ord_n - ord_chk, total);
        while (exp_ord.size() > 0) begin
            e = exp_ord.pop_front();
            exp_cnt[e]++;
            if (ord_chk < ord_n) begin
                check({tag, "_order"}, ord_log[ord_chk % LOGN], e);
                ord_chk++;
            end
        end
        check_data(tag);
        check_cnt(tag);
        check({tag, "_busy_arb"}, busy, 1);
        check({tag, "_cs_idle"}, eng_cs, 0);
        check({tag, "_mon_strobe"}, bad_strobe, 0);
        check({tag, "_mon_full"}, bad_full, 0);
        check({tag, "_mon_gap"}, bad_gap, 0);
    endtask

    task automatic do_reset();
        RSTN = 1'b0;
        tick(2);
        RSTN = 1'b1;
        for (int i = 0; i < NCH; i++) exp_cnt[i] = 0;
        model_last = NCH - 1;
    endtask

    task automatic wait_rd(input int ch, input string tag);
        int budget;
        budget = 80;
        while (!src_rd[ch] && budget > 0) begin
            tick();
            budget--;
        end
        check(tag, src_rd[ch], 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int sw0, rd0, bp_bad, cs0, budget, n;

        RSTN     = 1'b0;
        EN       = 1'b0;
        dst_full = '0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_cur_ch", cur_ch, 0);
        check("rst_cs", eng_cs, 0);
        check("rst_src_rd", src_rd, 0);
        check("rst_dst_wr", dst_wr, 0);
        check("rst_ch_cnt", ch_cnt, 0);
        tick(2);
        RSTN = 1'b1;
        tick(3);
        check("idle_no_en_busy", busy, 0);

        // Single channel with boundary data values.
        EN = 1'b1;
        load(0, 16'h0000);
        load(0, 16'h1234);
        load(0, 16'hFFFF);
        rd0 = rd_cnt[0];
        plan();
        finish_run("single");
        check("single_rd_pulses", rd_cnt[0] - rd0, 3);

        // Rotation: two channels with more than one burst each.
        do_reset();
        for (int j = 0; j < 6; j++) begin
            load(0, 16'($urandom));
            load(2, 16'($urandom));
        end
        sw0 = n_switch;
        plan();
        finish_run("rotate");
        check("rotate_switches", n_switch - sw0, 3);

        // Backpressure on channel 1 right after its read.
        for (int j = 0; j < 3; j++) load(1, 16'($urandom));
        plan();
        wait_rd(1, "bp_rd_seen");
        dst_full[1] = 1'b1;
        bp_bad = 0;
        repeat (20) begin
            tick();
            if (dst_wr[1] || cur_ch != 3'd1) bp_bad++;
        end
        check("bp_hold", bp_bad, 0);
        dst_full[1] = 1'b0;
        #1;
        check("bp_release_wr", dst_wr[1], 1);
        finish_run("bp");

        // EN dropped one cycle after the engine read: word still completes.
        load(2, 16'hA5A5);
        load(2, 16'h0F0F);
        wait_rd(2, "endrop_rd_seen");
        tick();
        EN = 1'b0;
        budget = 30;
        while (busy && budget > 0) begin
            tick();
            budget--;
        end
        check("endrop_idle", busy, 0);
        check("endrop_words", ord_n - ord_chk, 1);
        if (ord_chk < ord_n) begin
            check("endrop_ch", ord_log[ord_chk % LOGN], 2);
            exp_cnt[2]++;
            ord_chk++;
        end
        check_data("endrop");
        cs0 = cs_count;
        tick(10);
        check("endrop_cs_quiet", cs_count - cs0, 0);
        check("endrop_still_idle", busy, 0);
        check("endrop_leftover", src_wp[2] - src_rp[2], 1);
        model_last = 2;

        // Random traffic rounds, including the leftover word on channel 2.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NCH; i++) begin
                n = int'($urandom_range(0, 7)) + ((i == r) ? 1 : 0);
                for (int j = 0; j < n; j++) load(i, 16'($urandom));
            end
            plan();
            EN = 1'b1;
            finish_run($sformatf("rand%0d", r));
        end

        // Reset in the middle of a word on channel 1.
        for (int j = 0; j < 3; j++) load(1, 16'($urandom));
        wait_rd(1, "rstmid_rd_seen");
        tick();
        RSTN = 1'b0;
        #1;
        check("rstmid_busy", busy, 0);
        check("rstmid_cur_ch", cur_ch, 0);
        check("rstmid_cs", eng_cs, 0);
        check("rstmid_strobes", {src_rd, dst_wr}, 0);
        check("rstmid_ch_cnt", ch_cnt, 0);
        void'(exp_q[1].pop_front());   // abandoned word
        load(0, 16'($urandom));
        load(0, 16'($urandom));
        for (int j = 0; j < 3; j++) load(3, 16'($urandom));
        tick(2);
        RSTN = 1'b1;
        for (int i = 0; i < NCH; i++) exp_cnt[i] = 0;
        model_last = NCH - 1;
        check_data("rstmid_none");
        plan();
        finish_run("rstmid");

        // Completed-word statistics on channel 3.
        do_reset();
        for (int j = 0; j < 5; j++) load(3, 16'($urandom));
        plan();
        finish_run("stats");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/stream_sched.md
Name: stream_sched

Overview:
- Round-robin scheduler that time-shares one 16-bit FIFO-to-FIFO word-processing engine (inverter-style: CS/Empty/Full in, RD/WR out, one word per pass) among NCH source/destination FIFO channel pairs.
- Picks an eligible channel, asserts the engine start, and muxes the engine's FIFO handshakes and data to that channel.
- Holds the grant for up to BURST words, then rotates, switching only at engine word boundaries.
- Sits between the channel FIFO banks and the single engine instance.

Parameters:
- NCH, 4, number of channels (2..8)
- DW, 16, word width
- BURST, 4, max words per grant before forced rotation (1..15)

Ports:
- CLK  in  1  clock
- RSTN  in  1  asynchronous reset, active-low
- EN  in  1  scheduler enable
- src_empty  in  NCH  per-channel source FIFO empty
- src_rd  out  NCH  per-channel source FIFO read strobe
- src_data  in  NCH*DW  per-channel source FIFO read data, channel i at [i*DW +: DW]
- dst_full  in  NCH  per-channel destination FIFO full
- dst_wr  out  NCH  per-channel destination FIFO write strobe
- dst_data  out  DW  destination write data, broadcast to all channels
- eng_cs  out  1  engine start
- eng_empty  out  1  muxed Empty to engine
- eng_full  out  1  muxed Full to engine
- eng_rd  in  1  engine read strobe
- eng_di  out  DW  muxed read data to engine
- eng_wr  in  1  engine write strobe
- eng_do  in  DW  engine output word
- busy  out  1  state != IDLE
- cur_ch  out  3  granted channel index
- ch_cnt  out  NCH*16  per-channel completed-word counters (optional feature)

Behaviour:
- Reset: state IDLE, sel=0, last=NCH-1, burst_cnt=0, in_flight=0.
  - Outputs on reset: eng_cs=0, src_rd=0, dst_wr=0, busy=0, cur_ch=0, ch_cnt=0.
- The engine shares RSTN. Reset mid-word abandons the word with no further strobes.
- Engine timing: after a CS&~Empty sample it issues RD, then WR at least 3 cycles later (stalls while Full), then spends 1 FIN cycle before sampling CS again.
- Mux, combinational on registered sel:
  - eng_empty=src_empty[sel]; eng_full=dst_full[sel]; eng_di=src_data[sel]; dst_data=eng_do.
  - src_rd[sel]=eng_rd and dst_wr[sel]=eng_wr; other bits are 0.
  - Mux is held stable in RUN and DRAIN.
- in_flight: set on eng_rd, cleared on eng_wr. word_busy = in_flight | eng_rd.
- burst_done = (burst_cnt == BURST).
- eng_cs = (state==RUN) & EN & ~burst_done.
- FSM states: IDLE, ARB, RUN, DRAIN.
  - IDLE: EN=1 -> ARB.
  - ARB:
    - EN=0 -> IDLE.
    - Eligible channel: ~src_empty[i] & ~dst_full[i].
    - Search starts at last+1 with wrap-around and takes the first eligible channel.
    - If one is found: sel=i, last=i, burst_cnt=0, go to RUN. Otherwise stay in ARB.
    - eng_cs=0 in ARB.
  - RUN:
    - Each eng_wr increments burst_cnt, saturating at BURST.
    - When ~word_busy & (eng_empty | ~EN | burst_done): go to DRAIN.
    - dst_full alone never exits RUN; the engine stalls internally.
  - DRAIN: one cycle with eng_cs=0, covering the engine FIN cycle. Then ARB if EN=1, else IDLE.
- EN deasserted mid-word: the word completes (RD and WR both delivered to sel), then exit via DRAIN.
- A single eligible channel re-wins ARB after its burst. Minimum gap is 2 cycles (DRAIN + ARB).
- No strobe ever reaches a non-selected channel.

Optional Feature:
- STREAM_SCHED_STATS_EN defined:
  - ch_cnt[i] increments on each eng_wr while sel==i in RUN.
  - 16-bit, saturating at 0xFFFF; cleared only by reset.
- Undefined: ch_cnt is tied to 0 and no counter flops exist.

Decomposition:
- Package stream_sched_pkg:
  - State encoding localparams (IDLE=0, ARB=1, RUN=2, DRAIN=3).
  - Defaults NCH_DEF=4, DW_DEF=16, BURST_DEF=4.
  - Counter width CNT_W=16.
- Sub-module rr_pick: combinational rotating-priority picker.
  - Inputs: req[NCH], last index.
  - Outputs: valid, idx.

Test Plan:
- Single channel: ch0 holds 3 words {0x0000,0x1234,0xFFFF}, dst never full, EN=1.
  - ch0 destination receives {0xFFFF,0xEDCB,0x0000}.
  - Exactly 3 src_rd[0] and 3 dst_wr[0] pulses; FSM returns to ARB; other strobes 0.
- Rotation: ch0 and ch2 each hold 6 words, BURST=4.
  - Word order is ch0 x4, ch2 x4, ch0 x2, ch2 x2.
  - cur_ch changes only in ARB; eng_cs=0 for ≥2 cycles at each switch.
- Backpressure: dst_full[1]=1 for 20 cycles after ch1 RD.
  - No dst_wr[1] while full; WR follows within 1 cycle of release; sel stays 1 throughout.
- EN drop mid-word: EN deasserted 1 cycle after eng_rd.
  - Matching eng_wr still reaches the same channel; then DRAIN -> IDLE; eng_cs stays 0 afterwards.
- Reset mid-RUN: RSTN low for 2 cycles during a word.
  - All outputs reset immediately (busy=0, cur_ch=0, ch_cnt=0).
  - After release with EN=1, arbitration restarts at ch0.
- Stats (STREAM_SCHED_STATS_EN defined): ch3 processes 5 words -> ch_cnt[3]=5, others 0.
  - Macro undefined -> ch_cnt remains 0.
